rr_mux_4_1: RTL and testbench
=============================

Name: rr_mux_4_1

Overview:
- Registered, round-robin-arbitrated 4:1 data selector with valid/ready handshakes.
- Sits directly upstream of the 4:1 mux datapath. It chooses which of four sources wins each cycle, publishes the 2-bit select, and delivers the selected data one cycle later.
- Used wherever four producers share one consumer port.

Parameters:
- WIDTH, 4, data width of each source and of the output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- vld  input  4  per-source valid; bit i belongs to d<i>.
- d0  input  WIDTH  source 0 data.
- d1  input  WIDTH  source 1 data.
- d2  input  WIDTH  source 2 data.
- d3  input  WIDTH  source 3 data.
- rdy  output  4  per-source ready (one-hot grant, or all zero); combinational.
- out_vld  output  1  registered output valid.
- out_rdy  input  1  downstream ready.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  2  registered index of the source held in out_data.

Behaviour:
- Single clock. Reset is synchronous and active-high, sampled only on the clk rising edge.
- Reset values:
  - out_vld=0, out_data=0, out_sel=0.
  - Priority pointer ptr=0.
  - rdy=0 while rst is high.
- Acceptance condition:
  - can_take = !rst && (!out_vld || out_rdy).
- Arbitration (combinational):
  - Scan vld starting at index ptr, then ptr+1, ptr+2, ptr+3, all mod 4. The first set bit is the winner w.
  - If can_take and vld!=0, then rdy = one-hot(w); otherwise rdy=0.
- Transfer rule: source i transfers when vld[i] && rdy[i]. At most one source transfers per cycle.
- On a transfer, at the next edge:
  - out_data <= d<w>.
  - out_sel <= w.
  - out_vld <= 1.
  - ptr <= (w+1) mod 4; wrap from 3 to 0 is natural 2-bit overflow.
- Drain without refill: if out_vld && out_rdy && vld==0, then out_vld <= 0. out_data, out_sel and ptr hold.
- Stall: if out_vld && !out_rdy, then rdy=0 and out_vld, out_data, out_sel and ptr all hold. Output stays stable until accepted.
- Simultaneous output pop and new grant: both occur in the same cycle. out_vld stays 1 and data is replaced, giving full throughput of 1 item/cycle.
- Idle: ptr does not advance when nothing is granted.
- Latency: exactly 1 cycle from source handshake to out_vld/out_data.
- Fairness: a source holding vld high is granted within at most 4 grant cycles (after at most 3 other grants).
- X isolation: unselected data inputs may be X. Only d<w> may reach out_data, and out_data must never become X from an unselected source.
- Protocol requirements:
  - rdy may depend combinationally on vld and out_rdy.
  - Sources must not make vld depend on rdy.
  - A source that has raised vld keeps it and its data stable until its handshake.
- Reset mid-operation: a pending out_vld=1 item is discarded and ptr returns to 0. rdy is 0 in the reset cycle, so no source handshakes during reset.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then vld=0 with out_rdy=1 -> out_vld=0, out_data=0, out_sel=0 and rdy=0 every cycle.
- Single source: vld=4'b0100, d2=4'hC, out_rdy=1 -> rdy=4'b0100. Next cycle out_vld=1, out_data=4'hC, out_sel=2. Then vld=0 -> out_vld=0 one cycle later.
- Round-robin rotation: vld=4'b1111 held, d0..d3=4'hA,4'hB,4'hC,4'hD, out_rdy=1 -> out_sel sequence 0,1,2,3,0,… and out_data A,B,C,D,A,… with out_vld continuously 1.
- Back-pressure hold: output holds 4'hB/sel 1, out_rdy=0 for 3 cycles with vld=4'b1111 -> rdy=0 and out_data=4'hB, out_sel=1 stable. On out_rdy=1, rdy=4'b0100 and the next out_data=4'hC.
- Pointer wrap and skip: after a grant to 3 (ptr=0), vld=4'b1010 -> w=1 (skip 0). Next grant with vld=4'b1010 -> w=3. X on d0 and d2 never appears on out_data.
- Reset mid-flight: out_vld=1, out_sel=2, out_rdy=0, assert rst for 1 cycle -> out_vld=0, out_data=0, out_sel=0. With vld=4'b1111 after reset, the first grant is source 0.

Source files
------------

// File: rtl/rr_mux_4_1.sv
// Round-robin arbitrated 4:1 selector: picks one of four valid sources per cycle
// and presents its data, registered, one cycle after the handshake.
module rr_mux_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       vld,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       rdy,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    logic [1:0]       ptr;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             found;
    logic             can_take;
    logic             take;
    logic [WIDTH-1:0] sel_data;

    assign can_take = !rst && (!out_vld || out_rdy);

    // Scan from ptr upward; the 2-bit index wraps 3 -> 0 on its own.
    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && vld[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign take = found && can_take;
    assign rdy  = take ? (4'b0001 << win) : 4'b0000;

    // Only the winning source is routed; nothing else can leak into out_data.
    always_comb begin
        sel_data = '0;
        case (win)
            2'd0: sel_data = d0;
            2'd1: sel_data = d1;
            2'd2: sel_data = d2;
            2'd3: sel_data = d3;
            default: sel_data = '0;
        endcase
    end

    // Output stage: load on grant, drop valid on pop without refill, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_sel  <= 2'd0;
            ptr      <= 2'd0;
        end else if (take) begin
            out_vld  <= 1'b1;
            out_data <= sel_data;
            out_sel  <= win;
            ptr      <= win + 2'd1;
        end else if (out_vld && out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_4_1.sv
// Bench for rr_mux_4_1: directed scenarios with literal expectations plus a
// protocol-respecting random phase, all checked against a behavioural model.
module tb_rr_mux_4_1;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   vld;
    logic [W-1:0] d [4];
    logic [3:0]   rdy;
    logic         out_vld;
    logic         out_rdy;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;

    int total = 0;
    int passed = 0;

    rr_mux_4_1 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .vld(vld),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .rdy(rdy), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_data(out_data), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: pointer, held item, and the arbitration rule as plain ints.
    int           m_ptr = 0;
    bit           m_vld = 0;
    int           m_sel = 0;
    logic [W-1:0] m_data = '0;
    bit           m_init = 0;
    int           w;
    logic [3:0]   er;

    always @(negedge clk) begin
        w  = -1;
        er = 4'b0000;
        if (!rst && (!m_vld || out_rdy)) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && vld[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
        end
        if (w >= 0) er[w] = 1'b1;
        if (m_init) begin
            check("model_rdy", 32'(rdy), 32'(er));
            check("model_out_vld", 32'(out_vld), 32'(m_vld));
            check("model_out_sel", 32'(out_sel), 32'(m_sel));
            check("model_out_data", 32'(out_data), 32'(m_data));
        end
        if (rst) begin
            m_init = 1;
            m_ptr  = 0;
            m_vld  = 0;
            m_sel  = 0;
            m_data = '0;
        end else if (w >= 0) begin
            m_vld  = 1;
            m_sel  = w;
            m_data = d[w];
            m_ptr  = (w + 1) % 4;
        end else if (m_vld && out_rdy) begin
            m_vld = 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    logic [3:0] hs;

    initial begin
        rst = 1'b1; vld = 4'b0; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = '0;

        // Reset then idle
        tick; at_neg;
        check("reset_rdy", 32'(rdy), 32'h0);
        check("reset_out_vld", 32'(out_vld), 32'h0);
        tick; rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            at_neg;
            check("idle_out_vld", 32'(out_vld), 32'h0);
            check("idle_out_data", 32'(out_data), 32'h0);
            check("idle_out_sel", 32'(out_sel), 32'h0);
            check("idle_rdy", 32'(rdy), 32'h0);
            tick;
        end

        // Single source 2
        vld = 4'b0100; d[2] = 4'hC;
        at_neg; check("single_rdy", 32'(rdy), 32'h4);
        tick; vld = 4'b0000; d[2] = 4'h3;
        at_neg;
        check("single_out_vld", 32'(out_vld), 32'h1);
        check("single_out_data", 32'(out_data), 32'hC);
        check("single_out_sel", 32'(out_sel), 32'h2);
        tick; at_neg; check("single_drain", 32'(out_vld), 32'h0);

        // Rotation from a fresh pointer
        tick; rst = 1'b1; tick; rst = 1'b0;
        vld = 4'b1111; d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;
        for (int i = 0; i < 6; i++) begin
            at_neg;
            if (i > 0) begin
                check("rot_out_vld", 32'(out_vld), 32'h1);
                check("rot_out_sel", 32'(out_sel), 32'((i - 1) % 4));
                check("rot_out_data", 32'(out_data), 32'(4'hA + 4'((i - 1) % 4)));
            end
            tick;
        end

        // Back-pressure while holding B
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg;
            check("bp_rdy", 32'(rdy), 32'h0);
            check("bp_out_data", 32'(out_data), 32'hB);
            check("bp_out_sel", 32'(out_sel), 32'h1);
            tick;
        end
        out_rdy = 1'b1;
        at_neg; check("bp_release_rdy", 32'(rdy), 32'h4);
        tick;
        at_neg;
        check("bp_next_data", 32'(out_data), 32'hC);
        check("wrap_rdy3", 32'(rdy), 32'h8);

        // Pointer wrap and skip with junk on the idle sources
        tick; vld = 4'b1010; d[1] = 4'h5; d[3] = 4'h9;
        d[0] = 4'($urandom); d[2] = 4'($urandom);
        at_neg;
        check("wrap_data_d", 32'(out_data), 32'hD);
        check("wrap_rdy1", 32'(rdy), 32'h2);
        tick; d[0] = 4'($urandom); d[2] = 4'($urandom);
        at_neg;
        check("skip_data", 32'(out_data), 32'h5);
        check("skip_sel", 32'(out_sel), 32'h1);
        check("skip_rdy3", 32'(rdy), 32'h8);
        tick; vld = 4'b0000;
        at_neg;
        check("skip_data3", 32'(out_data), 32'h9);
        check("skip_sel3", 32'(out_sel), 32'h3);
        tick;

        // Reset mid-flight
        vld = 4'b0100; d[2] = 4'hC;
        tick; vld = 4'b0000; out_rdy = 1'b0;
        at_neg;
        check("mid_out_vld", 32'(out_vld), 32'h1);
        check("mid_out_sel", 32'(out_sel), 32'h2);
        tick; rst = 1'b1; vld = 4'b1111; d[0] = 4'h6;
        at_neg; check("mid_rst_rdy", 32'(rdy), 32'h0);
        tick; rst = 1'b0; out_rdy = 1'b1;
        at_neg;
        check("mid_out_vld0", 32'(out_vld), 32'h0);
        check("mid_out_data0", 32'(out_data), 32'h0);
        check("mid_out_sel0", 32'(out_sel), 32'h0);
        check("mid_first_grant", 32'(rdy), 32'h1);
        tick; at_neg;
        check("mid_grant_data", 32'(out_data), 32'h6);

        // Random phase: sources hold vld/data until their handshake
        vld = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            at_neg;
            hs = vld & rdy;
            tick;
            rst     = ($urandom_range(99) == 0);
            out_rdy = ($urandom_range(3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!(vld[i] && !hs[i])) begin
                    vld[i] = 1'($urandom_range(1));
                    d[i]   = 4'($urandom);
                end
            end
        end
        at_neg;
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
